// File: rtl/timer_bcd_counter_pkg.sv
// timer_bcd_counter_pkg: state encodings, mode values and BCD digit limits
// shared by the MM:SS timer and its digit counters.
package timer_bcd_counter_pkg;
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_PAUSE   = 2'd2;
   localparam logic [1:0] ST_EXPIRED = 2'd3;
   localparam logic MODE_UP   = 1'b0;
   localparam logic MODE_DOWN = 1'b1;
   localparam logic [3:0] DIGIT_MAX    = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   function automatic logic [3:0] bcd_clamp(input logic [3:0] v, input logic [3:0] max);
      return (v > max) ? max : v;
   endfunction
endpackage

// File: rtl/timer_bcd_counter_digit.sv
// timer_bcd_counter_digit: one BCD digit, 0..MAX_DIGIT, with inc/dec enables,
// carry/borrow out, sync clear/load (load clamped to MAX_DIGIT).
module timer_bcd_counter_digit
   import timer_bcd_counter_pkg::*;
#(
   parameter logic [3:0] MAX_DIGIT = DIGIT_MAX
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clr,
   input  logic       i_load,
   input  logic [3:0] i_load_val,
   input  logic       i_inc,
   input  logic       i_dec,
   input  logic       i_hold,
   output logic [3:0] o_val,
   output logic       o_co
);
   logic [3:0] r_val;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_val <= '0;
      else if (i_clr) r_val <= '0;
      else if (i_load) r_val <= bcd_clamp(i_load_val, MAX_DIGIT);
      else if (i_inc && !i_hold) r_val <= (r_val == MAX_DIGIT) ? 4'd0 : r_val + 4'd1;
      else if (i_dec && !i_hold) r_val <= (r_val == 4'd0) ? MAX_DIGIT : r_val - 4'd1;
   assign o_val = r_val;
   assign o_co  = (i_inc && r_val == MAX_DIGIT) || (i_dec && r_val == 4'd0);
endmodule

// File: rtl/timer_bcd_counter.sv
// timer_bcd_counter: MM:SS BCD stopwatch/countdown time base with run/pause FSM
// and tick prescaler; TIMER_ALARM_EN adds a post-expiry alarm held ALARM_SECS ticks.
module timer_bcd_counter
   import timer_bcd_counter_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1
`ifdef TIMER_ALARM_EN
   , parameter int ALARM_SECS = 5
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mode,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        load,
   input  logic [15:0] load_bcd,
   output logic [3:0]  bcd_m1,
   output logic [3:0]  bcd_m0,
   output logic [3:0]  bcd_s1,
   output logic [3:0]  bcd_s0,
   output logic        running,
   output logic        done,
   output logic        alarm
);
   localparam int TERM = CLK_HZ / TICK_HZ - 1;
   localparam int PW = (TERM > 0) ? $clog2(TERM + 1) : 1;
   localparam logic [PW-1:0] PTERM = PW'(TERM);
   logic [1:0]    r_state;
   logic          r_mode;
   logic          r_done;
   logic [PW-1:0] r_presc;
   logic [1:0]    w_next;
   logic [3:0]    w_co;
   logic [15:0]   w_bcd;
   logic          w_zero, w_load_acc, w_start, w_cnt_en, w_tick, w_dtick, w_expire, w_alarm;
   logic          w_up, w_dn;
   assign w_bcd      = {bcd_m1, bcd_m0, bcd_s1, bcd_s0};
   assign w_zero     = w_bcd == 16'h0000;
   assign w_load_acc = load && !clear && r_state != ST_RUN;
   assign w_start    = start_stop && !clear && !load && r_state == ST_IDLE &&
                       !(mode == MODE_DOWN && w_zero);
   assign w_cnt_en   = r_state == ST_RUN || (r_state == ST_EXPIRED && w_alarm);
   assign w_tick     = w_cnt_en && r_presc == PTERM;
   assign w_dtick    = w_tick && r_state == ST_RUN && !clear;
   assign w_up       = r_mode == MODE_UP;
   assign w_dn       = r_mode == MODE_DOWN;
   // Up expiry is the carry out of M1, which also freezes the chain at 99:59
   assign w_expire   = w_dtick && (w_up ? w_co[3] : w_bcd == 16'h0001);
   assign w_next = (clear || w_load_acc)                     ? ST_IDLE :
                   w_expire                                  ? ST_EXPIRED :
                   w_start                                   ? ST_RUN :
                   (start_stop && r_state == ST_RUN)         ? ST_PAUSE :
                   (start_stop && r_state == ST_PAUSE)       ? ST_RUN : r_state;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_mode  <= MODE_UP;
         r_done  <= 1'b0;
         r_presc <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= w_expire;
         if (w_start) r_mode <= mode;
         if (clear || w_load_acc) r_presc <= '0;
         else if (w_cnt_en) r_presc <= w_tick ? '0 : r_presc + PW'(1);
      end
   timer_bcd_counter_digit #(.MAX_DIGIT(DIGIT_MAX)) u_s0 (
      .clk(clk), .rst_n(rst_n), .i_clr(clear), .i_load(w_load_acc), .i_load_val(load_bcd[3:0]),
      .i_inc(w_dtick && w_up), .i_dec(w_dtick && w_dn), .i_hold(w_co[3]),
      .o_val(bcd_s0), .o_co(w_co[0]));
   timer_bcd_counter_digit #(.MAX_DIGIT(SEC_TENS_MAX)) u_s1 (
      .clk(clk), .rst_n(rst_n), .i_clr(clear), .i_load(w_load_acc), .i_load_val(load_bcd[7:4]),
      .i_inc(w_co[0] && w_up), .i_dec(w_co[0] && w_dn), .i_hold(w_co[3]),
      .o_val(bcd_s1), .o_co(w_co[1]));
   timer_bcd_counter_digit #(.MAX_DIGIT(DIGIT_MAX)) u_m0 (
      .clk(clk), .rst_n(rst_n), .i_clr(clear), .i_load(w_load_acc), .i_load_val(load_bcd[11:8]),
      .i_inc(w_co[1] && w_up), .i_dec(w_co[1] && w_dn), .i_hold(w_co[3]),
      .o_val(bcd_m0), .o_co(w_co[2]));
   timer_bcd_counter_digit #(.MAX_DIGIT(DIGIT_MAX)) u_m1 (
      .clk(clk), .rst_n(rst_n), .i_clr(clear), .i_load(w_load_acc), .i_load_val(load_bcd[15:12]),
      .i_inc(w_co[2] && w_up), .i_dec(w_co[2] && w_dn), .i_hold(w_co[3]),
      .o_val(bcd_m1), .o_co(w_co[3]));
`ifdef TIMER_ALARM_EN
   localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS + 1) : 1;
   logic          r_alarm;
   logic [AW-1:0] r_alarm_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_alarm     <= 1'b0;
         r_alarm_cnt <= '0;
      end else if (w_expire) begin
         r_alarm     <= 1'b1;
         r_alarm_cnt <= AW'(ALARM_SECS);
      end else if (clear || load || start_stop) r_alarm <= 1'b0;
      else if (w_tick && r_alarm) begin
         r_alarm     <= r_alarm_cnt != AW'(1);
         r_alarm_cnt <= r_alarm_cnt - AW'(1);
      end
   assign w_alarm = r_alarm;
`else
   assign w_alarm = 1'b0;
`endif
   assign running = r_state == ST_RUN;
   assign done    = r_done;
   assign alarm   = w_alarm;
endmodule

// File: tb/tb_timer_bcd_counter.sv
// tb_timer_bcd_counter: scoreboard bench for timer_bcd_counter at CLK_HZ=10, TICK_HZ=1
// (tick every 10 cycles); expectations are queued with a due edge and compared at negedge.
module tb_timer_bcd_counter;
`ifdef TIMER_ALARM_EN
   localparam bit AEN = 1'b1;
`else
   localparam bit AEN = 1'b0;
`endif
   localparam logic [2:0] P_SS = 3'b001, P_LD = 3'b010, P_CLR = 3'b100;
   typedef struct { string tag; int due; logic [31:0] exp; } exp_t;
   exp_t sb[$];
   int edges = 0;
   int n_checks = 0;
   int n_errors = 0;
   logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, start_stop = 1'b0, clear = 1'b0, load = 1'b0;
   logic [15:0] load_bcd = '0;
   logic [3:0] bcd_m1, bcd_m0, bcd_s1, bcd_s0;
   logic running, done, alarm;
   timer_bcd_counter #(
      .CLK_HZ(10), .TICK_HZ(1)
`ifdef TIMER_ALARM_EN
      , .ALARM_SECS(2)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .start_stop(start_stop), .clear(clear),
      .load(load), .load_bcd(load_bcd), .bcd_m1(bcd_m1), .bcd_m0(bcd_m0), .bcd_s1(bcd_s1),
      .bcd_s0(bcd_s0), .running(running), .done(done), .alarm(alarm));
   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h (alarm,running,done,MMSS)", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] obs();
      return {13'd0, alarm, running, done, bcd_m1, bcd_m0, bcd_s1, bcd_s0};
   endfunction
   task automatic push_exp(input string tag, input int lat, input bit al, input bit run,
                           input bit dn, input logic [15:0] d);
      sb.push_back('{tag, edges + lat, {13'd0, al, run, dn, d}});
   endtask
   always @(negedge clk)
      while (sb.size() > 0 && sb[0].due <= edges) begin
         exp_t e;
         e = sb.pop_front();
         check(e.due == edges ? e.tag : {e.tag, "_late"}, obs(), e.exp);
      end
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic pulse(input logic [2:0] p, input logic [15:0] v);
      {clear, load, start_stop} = p;
      load_bcd = v;
      cyc(1);
      {clear, load, start_stop} = 3'b000;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end
   initial begin
      push_exp("rst_hold", 0, 0, 0, 0, 16'h0000);
      cyc(2);
      rst_n = 1'b1;
      push_exp("rst", 0, 0, 0, 0, 16'h0000);
      // stopwatch from zero: ten ticks, S0 rolls into S1
      mode = 1'b0;
      pulse(P_SS, 16'h0);
      push_exp("run_start", 0, 0, 1, 0, 16'h0000);
      push_exp("up_00_09", 99, 0, 1, 0, 16'h0009);
      push_exp("up_00_10", 100, 0, 1, 0, 16'h0010);
      cyc(100);
      pulse(P_SS, 16'h0);
      push_exp("pause", 0, 0, 0, 0, 16'h0010);
      pulse(P_LD, 16'h0059);
      push_exp("load_0059", 0, 0, 0, 0, 16'h0059);
      pulse(P_SS, 16'h0);
      push_exp("run2", 0, 0, 1, 0, 16'h0059);
      pulse(P_LD, 16'h1234);
      push_exp("load_in_run", 0, 0, 1, 0, 16'h0059);
      push_exp("up_pre_carry", 8, 0, 1, 0, 16'h0059);
      push_exp("up_01_00", 9, 0, 1, 0, 16'h0100);
      cyc(9);
      pulse(P_SS, 16'h0);
      push_exp("pause2", 0, 0, 0, 0, 16'h0100);
      pulse(P_LD, 16'h9959);
      push_exp("load_9959", 0, 0, 0, 0, 16'h9959);
      pulse(P_SS, 16'h0);
      push_exp("sat_pre", 9, 0, 1, 0, 16'h9959);
      push_exp("sat_done", 10, AEN, 0, 1, 16'h9959);
      push_exp("sat_done_1cyc", 11, AEN, 0, 0, 16'h9959);
      cyc(11);
      pulse(P_SS, 16'h0);
      push_exp("expired_ss", 0, 0, 0, 0, 16'h9959);
      // countdown to expiry, alarm window
      pulse(P_LD, 16'h0002);
      push_exp("load_0002", 0, 0, 0, 0, 16'h0002);
      mode = 1'b1;
      pulse(P_SS, 16'h0);
      push_exp("dn_00_01", 10, 0, 1, 0, 16'h0001);
      push_exp("dn_pre_exp", 19, 0, 1, 0, 16'h0001);
      push_exp("dn_exp", 20, AEN, 0, 1, 16'h0000);
      push_exp("alarm_hold", 39, AEN, 0, 0, 16'h0000);
      push_exp("alarm_end", 40, 0, 0, 0, 16'h0000);
      cyc(45);
      pulse(P_CLR, 16'h0);
      push_exp("clear_exp", 0, 0, 0, 0, 16'h0000);
      pulse(P_SS, 16'h0);
      push_exp("dn_zero_blocked", 0, 0, 0, 0, 16'h0000);
      push_exp("dn_zero_still", 12, 0, 0, 0, 16'h0000);
      cyc(12);
      pulse(P_LD, 16'h7F9C);
      push_exp("load_clamp", 0, 0, 0, 0, 16'h7959);
      // pause at prescaler 4, flip mode while paused, resume
      pulse(P_SS, 16'h0);
      push_exp("run_dn", 0, 0, 1, 0, 16'h7959);
      cyc(3);
      pulse(P_SS, 16'h0);
      push_exp("pause_p4", 0, 0, 0, 0, 16'h7959);
      mode = 1'b0;
      cyc(3);
      pulse(P_SS, 16'h0);
      push_exp("resume", 0, 0, 1, 0, 16'h7959);
      push_exp("resume_pre", 5, 0, 1, 0, 16'h7959);
      push_exp("resume_tick", 6, 0, 1, 0, 16'h7958);
      cyc(6);
      pulse(P_CLR | P_LD | P_SS, 16'h1234);
      push_exp("clr_ld_ss", 0, 0, 0, 0, 16'h0000);
      push_exp("clr_idle", 15, 0, 0, 0, 16'h0000);
      cyc(15);
      // asynchronous reset mid-count
      mode = 1'b0;
      pulse(P_SS, 16'h0);
      push_exp("run3", 0, 0, 1, 0, 16'h0000);
      push_exp("pre_rst", 24, 0, 1, 0, 16'h0002);
      cyc(25);
      #2;
      rst_n = 1'b0;
      push_exp("async_rst", 0, 0, 0, 0, 16'h0000);
      cyc(2);
      rst_n = 1'b1;
      push_exp("after_rst", 5, 0, 0, 0, 16'h0000);
      cyc(5);
      // clear while the alarm is up
      pulse(P_LD, 16'h0001);
      push_exp("load_0001", 0, 0, 0, 0, 16'h0001);
      mode = 1'b1;
      pulse(P_SS, 16'h0);
      push_exp("exp2", 10, AEN, 0, 1, 16'h0000);
      push_exp("alarm_mid", 12, AEN, 0, 0, 16'h0000);
      cyc(13);
      pulse(P_CLR, 16'h0);
      push_exp("alarm_clr", 0, 0, 0, 0, 16'h0000);
      for (int i = 0; i < 50 && sb.size() > 0; i++) cyc(1);
      cyc(1);
      check("sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
